// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_sequencer
// Description : Issue stage for the floating-point adder. Buffers operand
//               pairs in a small FIFO, runs the adder on one pair at a time
//               with a one-cycle adder reset pulse, holds the operands for a
//               fixed window, then returns the captured result/status over a
//               valid/ready handshake.
//               Optional feature macro: FPU_SEQ_ZERO_BYPASS_EN (pairs with a
//               zero operand are answered directly without running the adder).
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_op_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 34
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    output logic [31:0]                op_a_out,
    output logic [31:0]                op_b_out,
    output logic                       fpu_rst_n,
    input  logic [31:0]                res_data_in,
    input  logic [3:0]                 res_status_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [3:0]                 out_status,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]          c_ST_EXACT  = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t                r_state;
    logic [31:0]           r_mem_a [DEPTH];
    logic [31:0]           r_mem_b [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_HOLD_W-1:0]   r_hold;
    logic [31:0]           r_op_a;
    logic [31:0]           r_op_b;
    logic                  r_fpu_rst_n;
    logic                  r_out_valid;
    logic [31:0]           r_out_data;
    logic [3:0]            r_out_status;

    logic                  w_push;
    logic                  w_pop;
    logic [31:0]           w_head_a;
    logic [31:0]           w_head_b;

    assign w_head_a = r_mem_a[r_rd_ptr];
    assign w_head_b = r_mem_b[r_rd_ptr];
    assign in_ready = (r_count < c_FULL);
    assign w_push   = in_valid && in_ready;
    // Every IDLE exit consumes the head, whether it runs the adder or not.
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

`ifdef FPU_SEQ_ZERO_BYPASS_EN
    logic        w_a_zero;
    logic        w_b_zero;
    logic [31:0] w_bypass_data;

    assign w_a_zero = (w_head_a[30:0] == 31'd0);
    assign w_b_zero = (w_head_b[30:0] == 31'd0);

    // Sum with a zero operand is the other operand; 0+0 keeps sign only if both negative.
    always_comb begin
        w_bypass_data = w_head_b;
        if (w_a_zero && w_b_zero) begin
            w_bypass_data = {w_head_a[31] & w_head_b[31], 31'd0};
        end else if (w_b_zero) begin
            w_bypass_data = w_head_a;
        end
    end
`endif

    // Operand FIFO: storage, wrapping pointers and occupancy.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencing FSM: load pair, pulse adder reset, hold window, return result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_fpu_rst_n  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_status <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fpu_rst_n <= 1'b1;
                    if (r_count != '0) begin
`ifdef FPU_SEQ_ZERO_BYPASS_EN
                        if (w_a_zero || w_b_zero) begin
                            r_state      <= S_RESULT;
                            r_out_valid  <= 1'b1;
                            r_out_data   <= w_bypass_data;
                            r_out_status <= c_ST_EXACT;
                        end else
`endif
                        begin
                            r_state     <= S_LOAD;
                            r_op_a      <= w_head_a;
                            r_op_b      <= w_head_b;
                            r_fpu_rst_n <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    r_state     <= S_RUN;
                    r_fpu_rst_n <= 1'b1;
                    r_hold      <= '0;
                end
                S_RUN: begin
                    if (r_hold == c_HOLD_LAST) begin
                        r_state      <= S_RESULT;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= res_data_in;
                        r_out_status <= res_status_in;
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_a_out   = r_op_a;
    assign op_b_out   = r_op_b;
    assign fpu_rst_n  = r_fpu_rst_n;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_status = r_out_status;
    assign busy       = (r_state != S_IDLE);
    assign count      = r_count;

endmodule
`default_nettype wire
